// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//
// Streams instruction descriptors into a 32-bit MIPS-style instruction memory.
// A program starts at word 0. Each legal descriptor that is accepted becomes
// one write strobe in the following cycle. Illegal opcodes are consumed
// silently: they raise err for one cycle and do not advance the pointer.
// After the last word (2^ADDR_W-1) has been written the block parks in FULL.
// It stays there until stop or a new start arrives.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, stop         begin a program at word 0 / end the current program
//   in_valid, in_ready  descriptor handshake (in_ready is combinational)
//   op, rs, rt, rd      opcode selector and register fields
//   imm                 16-bit immediate for addi/lw/sw
//   target              absolute word address of a beq destination
//   mem_we              one-cycle write strobe
//   mem_addr            write word address
//   mem_wdata           encoded instruction word
//   count               words written since the last start (ADDR_W+1 bits)
//   busy, full          busy in RUN/FULL, full only in FULL
//   done                one-cycle pulse when a program is ended by stop
//   err                 one-cycle pulse when an illegal opcode was consumed
// ----------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [ADDR_W-1:0] target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_t;

    // Incoming descriptor, bundled so the encoder sees one object.
    typedef struct packed {
        logic [3:0]        op;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [15:0]       imm;
        logic [ADDR_W-1:0] target;
    } desc_t;

    state_t            state, state_nxt;
    desc_t             desc;
    logic [ADDR_W-1:0] ptr;
    logic              xfer, legal, wr, bad, last;
    logic [ADDR_W-1:0] off;
    logic [15:0]       off16;
    logic [31:0]       enc;

    assign desc  = '{op: op, rs: rs, rt: rt, rd: rd, imm: imm, target: target};

    assign xfer  = in_valid & in_ready;
    assign legal = (desc.op <= 4'd8);
    assign wr    = xfer & legal;
    assign bad   = xfer & ~legal;
    assign last  = (ptr == {ADDR_W{1'b1}});

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state. start beats stop, and both beat the write that
    // would fill the memory. The fill write cannot coincide with start or
    // stop anyway, because in_ready is low in that case.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = RUN;
        else if (stop)
            state_nxt = IDLE;
        else if (state == RUN && wr && last)
            state_nxt = FULL;
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        full     = 1'b0;
        case (state)
            RUN: begin
                busy     = 1'b1;
                in_ready = ~start & ~stop;
            end
            FULL: begin
                busy = 1'b1;
                full = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction encoding.
    // The beq offset is relative to the word after the branch. It is
    // computed in ADDR_W-bit arithmetic so that it wraps modulo the memory
    // size. It is then sign-extended so that it reads as a two's-complement
    // word offset.
    // ------------------------------------------------------------------
    assign off   = desc.target - (ptr + ADDR_W'(1));
    assign off16 = 16'(signed'(off));

    always_comb begin
        enc = 32'h0;
        case (desc.op)
            4'd0:    enc = {6'h00, desc.rs, desc.rt, desc.rd, 5'h00, 6'h20};
            4'd1:    enc = {6'h00, desc.rs, desc.rt, desc.rd, 5'h00, 6'h22};
            4'd2:    enc = {6'h00, desc.rs, desc.rt, desc.rd, 5'h00, 6'h24};
            4'd3:    enc = {6'h00, desc.rs, desc.rt, desc.rd, 5'h00, 6'h25};
            4'd4:    enc = {6'h00, desc.rs, desc.rt, desc.rd, 5'h00, 6'h2A};
            4'd5:    enc = {6'h08, desc.rs, desc.rt, desc.imm};
            4'd6:    enc = {6'h23, desc.rs, desc.rt, desc.imm};
            4'd7:    enc = {6'h2B, desc.rs, desc.rt, desc.imm};
            4'd8:    enc = {6'h04, desc.rs, desc.rt, off16};
            default: enc = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: pointer, count and the registered memory-write port.
    // mem_addr and mem_wdata hold the last write and are only
    // meaningful while mem_we is high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= wr;
            err    <= bad;
            done   <= stop & ~start & (state != IDLE);
            if (start) begin
                ptr   <= '0;
                count <= '0;
            end else if (wr) begin
                // The pointer wraps to 0 on the last word. FULL then blocks
                // any further write, so word 0 is never overwritten.
                ptr       <= ptr + ADDR_W'(1);
                count     <= count + (ADDR_W + 1)'(1);
                mem_addr  <= ptr;
                mem_wdata <= enc;
            end
        end
    end

endmodule
